// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: flushes the pipeline, captures mepc/mcause/mtval and
// mstatus.MIE/MPIE on exceptions, interrupts and mret, then hands fetch a redirect target.
module trap_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter logic [31:0] RESET_VECTOR = 32'h0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        exc_valid,
   input  logic [3:0]  exc_cause,
   input  logic [31:0] exc_tval,
   input  logic [2:0]  irq_pending,
   input  logic [2:0]  irq_enable,
   input  logic        mret_valid,
   input  logic [31:0] mepc_adr,
   input  logic [31:0] mtvec,
   input  logic        csr_we,
   input  logic [11:0] csr_addr,
   input  logic [31:0] csr_wdata,
   input  logic        redirect_ack,
   output logic        trap_flush,
   output logic        clear_counter,
   output logic        pc_redirect_valid,
   output logic [31:0] pc_redirect,
   output logic [31:0] mepc_q,
   output logic [31:0] mcause_q,
   output logic [31:0] mtval_q,
   output logic        mstatus_mie,
   output logic        mstatus_mpie,
   output logic        busy
);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      FLUSH      = 3'd1,
      CAPTURE    = 3'd2,
      REDIRECT   = 3'd3,
      MRET_FLUSH = 3'd4
   } state_t;

   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

   state_t      state;
   state_t      next_state;
   logic [2:0]  flush_cnt;
   logic [31:0] pend_cause;
   logic [31:0] pend_tval;

   logic [2:0]  irq_active;
   logic        irq_taken;
   logic        trap_start;
   logic [3:0]  irq_code;
   logic [31:0] trap_base;
   logic [31:0] trap_target;
   logic        trap_flush_d;
   logic        clear_counter_d;
   logic        redirect_valid_d;

   assign irq_active = irq_pending & irq_enable;
   assign irq_taken  = mstatus_mie & (|irq_active);
   assign trap_start = (state == IDLE) & (exc_valid | irq_taken);
   assign busy       = (state != IDLE);

   // Interrupt bits are {MEIP, MTIP, MSIP}; external beats software beats timer.
   always_comb begin
      irq_code = 4'd0;
      if (irq_active[2])
         irq_code = 4'd11;
      else if (irq_active[0])
         irq_code = 4'd3;
      else if (irq_active[1])
         irq_code = 4'd7;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (exc_valid || irq_taken)
               next_state = FLUSH;
            else if (mret_valid)
               next_state = MRET_FLUSH;
         end
         FLUSH:      if (flush_cnt == 3'd0) next_state = CAPTURE;
         CAPTURE:    next_state = REDIRECT;
         REDIRECT:   if (redirect_ack) next_state = IDLE;
         MRET_FLUSH: next_state = REDIRECT;
         default:    next_state = IDLE;
      endcase
   end

   // Outputs are registered, so they are decoded from the state being entered.
   always_comb begin
      trap_flush_d     = (next_state != IDLE);
      clear_counter_d  = (next_state == CAPTURE);
      redirect_valid_d = (next_state == REDIRECT);
      trap_base        = {mtvec[31:2], 2'b00};
      trap_target      = trap_base;
      if (mtvec[1:0] == 2'b01 && pend_cause[31])
         trap_target = trap_base + {26'd0, pend_cause[3:0], 2'b00};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         flush_cnt         <= 3'd0;
         pend_cause        <= 32'd0;
         pend_tval         <= 32'd0;
         trap_flush        <= 1'b0;
         clear_counter     <= 1'b0;
         pc_redirect_valid <= 1'b0;
         pc_redirect       <= RESET_VECTOR;
         mepc_q            <= 32'd0;
         mcause_q          <= 32'd0;
         mtval_q           <= 32'd0;
         mstatus_mie       <= 1'b0;
         mstatus_mpie      <= 1'b0;
      end else begin
         trap_flush        <= trap_flush_d;
         clear_counter     <= clear_counter_d;
         pc_redirect_valid <= redirect_valid_d;

         if (trap_start) begin
            flush_cnt <= FLUSH_LOAD;
            if (exc_valid) begin
               pend_cause <= {28'd0, exc_cause};
               pend_tval  <= exc_tval;
            end else begin
               pend_cause <= {1'b1, 27'd0, irq_code};
               pend_tval  <= 32'd0;
            end
         end else if (state == FLUSH && flush_cnt != 3'd0) begin
            flush_cnt <= flush_cnt - 3'd1;
         end

         // Software writes only land while no trap sequence owns the CSRs.
         if (state == IDLE && csr_we) begin
            case (csr_addr)
               12'h300: begin
                  mstatus_mie  <= csr_wdata[3];
                  mstatus_mpie <= csr_wdata[7];
               end
               12'h341: mepc_q   <= {csr_wdata[31:2], 2'b00};
               12'h342: mcause_q <= csr_wdata;
               12'h343: mtval_q  <= csr_wdata;
               default: ;
            endcase
         end

         if (state == CAPTURE) begin
            mepc_q       <= {mepc_adr[31:2], 2'b00};
            mcause_q     <= pend_cause;
            mtval_q      <= pend_tval;
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
            pc_redirect  <= trap_target;
         end

         if (state == MRET_FLUSH) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
            pc_redirect  <= mepc_q;
         end
      end
   end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: a per-cycle vector table for the exception/mret flow,
// followed by hand-written sequences for interrupts, masking, ack stall and reset.
module tb_trap_ctrl;

   localparam logic [31:0] RV = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        exc_valid;
   logic [3:0]  exc_cause;
   logic [31:0] exc_tval;
   logic [2:0]  irq_pending;
   logic [2:0]  irq_enable;
   logic        mret_valid;
   logic [31:0] mepc_adr;
   logic [31:0] mtvec;
   logic        csr_we;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata;
   logic        redirect_ack;
   logic        trap_flush;
   logic        clear_counter;
   logic        pc_redirect_valid;
   logic [31:0] pc_redirect;
   logic [31:0] mepc_q;
   logic [31:0] mcause_q;
   logic [31:0] mtval_q;
   logic        mstatus_mie;
   logic        mstatus_mpie;
   logic        busy;

   int checks = 0;
   int fails  = 0;

   trap_ctrl #(.FLUSH_CYCLES(2), .RESET_VECTOR(RV)) dut (
      .clk(clk), .reset_n(reset_n),
      .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_tval(exc_tval),
      .irq_pending(irq_pending), .irq_enable(irq_enable), .mret_valid(mret_valid),
      .mepc_adr(mepc_adr), .mtvec(mtvec),
      .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
      .redirect_ack(redirect_ack),
      .trap_flush(trap_flush), .clear_counter(clear_counter),
      .pc_redirect_valid(pc_redirect_valid), .pc_redirect(pc_redirect),
      .mepc_q(mepc_q), .mcause_q(mcause_q), .mtval_q(mtval_q),
      .mstatus_mie(mstatus_mie), .mstatus_mpie(mstatus_mpie), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        exc_valid;
      logic [3:0]  exc_cause;
      logic [31:0] exc_tval;
      logic        mret_valid;
      logic        csr_we;
      logic [11:0] csr_addr;
      logic [31:0] csr_wdata;
      logic        redirect_ack;
      logic        e_flush;
      logic        e_clr;
      logic        e_valid;
      logic [31:0] e_pcr;
      logic [31:0] e_mepc;
      logic [31:0] e_mcause;
      logic [31:0] e_mtval;
      logic        e_mie;
      logic        e_mpie;
      logic        e_busy;
   } vec_t;

   vec_t vecs[12];

   function automatic vec_t mk(
      input logic ev, input logic [3:0] ec, input logic [31:0] et, input logic mr,
      input logic we, input logic [11:0] ad, input logic [31:0] wd, input logic ack,
      input logic fl, input logic cl, input logic vl, input logic [31:0] pcr,
      input logic [31:0] mepc, input logic [31:0] mcause, input logic [31:0] mtval,
      input logic mie, input logic mpie, input logic bsy);
      vec_t v;
      v.exc_valid = ev;  v.exc_cause = ec;  v.exc_tval = et;  v.mret_valid = mr;
      v.csr_we = we;     v.csr_addr = ad;   v.csr_wdata = wd; v.redirect_ack = ack;
      v.e_flush = fl;    v.e_clr = cl;      v.e_valid = vl;   v.e_pcr = pcr;
      v.e_mepc = mepc;   v.e_mcause = mcause; v.e_mtval = mtval;
      v.e_mie = mie;     v.e_mpie = mpie;   v.e_busy = bsy;
      return v;
   endfunction

   task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %08h, expected %08h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      exc_valid    = v.exc_valid;
      exc_cause    = v.exc_cause;
      exc_tval     = v.exc_tval;
      mret_valid   = v.mret_valid;
      csr_we       = v.csr_we;
      csr_addr     = v.csr_addr;
      csr_wdata    = v.csr_wdata;
      redirect_ack = v.redirect_ack;
   endtask

   task automatic checkOutput(input int idx, input vec_t v);
      checkField($sformatf("v%0d.trap_flush", idx), 32'(trap_flush), 32'(v.e_flush));
      checkField($sformatf("v%0d.clear_counter", idx), 32'(clear_counter), 32'(v.e_clr));
      checkField($sformatf("v%0d.redirect_valid", idx), 32'(pc_redirect_valid), 32'(v.e_valid));
      checkField($sformatf("v%0d.pc_redirect", idx), pc_redirect, v.e_pcr);
      checkField($sformatf("v%0d.mepc", idx), mepc_q, v.e_mepc);
      checkField($sformatf("v%0d.mcause", idx), mcause_q, v.e_mcause);
      checkField($sformatf("v%0d.mtval", idx), mtval_q, v.e_mtval);
      checkField($sformatf("v%0d.mie", idx), 32'(mstatus_mie), 32'(v.e_mie));
      checkField($sformatf("v%0d.mpie", idx), 32'(mstatus_mpie), 32'(v.e_mpie));
      checkField($sformatf("v%0d.busy", idx), 32'(busy), 32'(v.e_busy));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n = 1'b0;
      exc_valid = 1'b0; exc_cause = 4'd0; exc_tval = 32'd0;
      irq_pending = 3'd0; irq_enable = 3'd0; mret_valid = 1'b0;
      mepc_adr = 32'h100; mtvec = 32'h200;
      csr_we = 1'b0; csr_addr = 12'd0; csr_wdata = 32'd0; redirect_ack = 1'b0;

      // Exception with FLUSH_CYCLES=2, then mret and software CSR writes; one row per cycle.
      vecs[0]  = mk(0,0,0,0, 1,12'h300,32'h8,  0, 0,0,0,RV,     0,    0,0,         1,0,0);
      vecs[1]  = mk(1,2,32'hDEAD,0, 0,0,0,     0, 1,0,0,RV,     0,    0,0,         1,0,1);
      vecs[2]  = mk(0,0,0,0, 1,12'h343,32'h55, 0, 1,0,0,RV,     0,    0,0,         1,0,1);
      vecs[3]  = mk(0,0,0,0, 0,0,0,            0, 1,1,0,RV,     0,    0,0,         1,0,1);
      vecs[4]  = mk(0,0,0,0, 0,0,0,            0, 1,0,1,32'h200,32'h100,2,32'hDEAD,0,1,1);
      vecs[5]  = mk(0,0,0,0, 0,0,0,            1, 0,0,0,32'h200,32'h100,2,32'hDEAD,0,1,0);
      vecs[6]  = mk(0,0,0,1, 0,0,0,            0, 1,0,0,32'h200,32'h100,2,32'hDEAD,0,1,1);
      vecs[7]  = mk(0,0,0,0, 0,0,0,            0, 1,0,1,32'h100,32'h100,2,32'hDEAD,1,1,1);
      vecs[8]  = mk(0,0,0,0, 0,0,0,            1, 0,0,0,32'h100,32'h100,2,32'hDEAD,1,1,0);
      vecs[9]  = mk(0,0,0,0, 1,12'h341,32'h123,0, 0,0,0,32'h100,32'h120,2,32'hDEAD,1,1,0);
      vecs[10] = mk(0,0,0,0, 1,12'h342,32'h7,  0, 0,0,0,32'h100,32'h120,7,32'hDEAD,1,1,0);
      vecs[11] = mk(0,0,0,0, 1,12'h343,32'h99, 0, 0,0,0,32'h100,32'h120,7,32'h99,  1,1,0);

      repeat (2) @(posedge clk);
      #1;
      checkField("rst.trap_flush", 32'(trap_flush), 32'd0);
      checkField("rst.redirect_valid", 32'(pc_redirect_valid), 32'd0);
      checkField("rst.pc_redirect", pc_redirect, RV);
      checkField("rst.busy", 32'(busy), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i]);
         step();
         checkOutput(i, vecs[i]);
      end
      applyStimulus(mk(0,0,0,0, 0,0,0, 0, 0,0,0,0, 0,0,0, 0,0,0));

      // Vectored mode, MEIP and MTIP both pending: MEIP (code 11) wins.
      mtvec = 32'h401; mepc_adr = 32'h307;
      irq_pending = 3'b110; irq_enable = 3'b111;
      step();
      checkField("irq.flush_start", 32'(trap_flush), 32'd1);
      repeat (3) step();
      checkField("irq.redirect_valid", 32'(pc_redirect_valid), 32'd1);
      checkField("irq.pc_redirect", pc_redirect, 32'h42C);
      checkField("irq.mcause", mcause_q, 32'h8000_000B);
      checkField("irq.mtval", mtval_q, 32'd0);
      checkField("irq.mepc", mepc_q, 32'h304);
      checkField("irq.mie", 32'(mstatus_mie), 32'd0);
      checkField("irq.mpie", 32'(mstatus_mpie), 32'd1);
      irq_pending = 3'b000; redirect_ack = 1'b1;
      step();
      redirect_ack = 1'b0;
      checkField("irq.busy_after_ack", 32'(busy), 32'd0);

      // MSIP pending but MIE=0: nothing happens until software sets MIE.
      irq_pending = 3'b001; irq_enable = 3'b001;
      for (int i = 0; i < 3; i++) begin
         step();
         checkField($sformatf("mask%0d.busy", i), 32'(busy), 32'd0);
         checkField($sformatf("mask%0d.trap_flush", i), 32'(trap_flush), 32'd0);
      end
      csr_we = 1'b1; csr_addr = 12'h300; csr_wdata = 32'h8;
      step();
      csr_we = 1'b0;
      checkField("mask.mie_set", 32'(mstatus_mie), 32'd1);
      checkField("mask.flush_not_yet", 32'(trap_flush), 32'd0);
      step();
      checkField("mask.flush_two_later", 32'(trap_flush), 32'd1);
      repeat (3) step();
      checkField("mask.mcause", mcause_q, 32'h8000_0003);
      checkField("mask.pc_redirect", pc_redirect, 32'h40C);

      // Fetch stalls the ack for 5 cycles; an exception in that window is dropped.
      for (int i = 0; i < 5; i++) begin
         exc_valid = (i == 1); exc_cause = 4'd5; exc_tval = 32'hBAD;
         step();
         checkField($sformatf("stall%0d.valid", i), 32'(pc_redirect_valid), 32'd1);
         checkField($sformatf("stall%0d.pc_redirect", i), pc_redirect, 32'h40C);
         checkField($sformatf("stall%0d.mcause", i), mcause_q, 32'h8000_0003);
      end
      exc_valid = 1'b0; irq_pending = 3'b000; redirect_ack = 1'b1;
      step();
      redirect_ack = 1'b0;
      checkField("stall.valid_dropped", 32'(pc_redirect_valid), 32'd0);
      step();
      checkField("stall.busy", 32'(busy), 32'd0);
      checkField("stall.mtval", mtval_q, 32'd0);
      checkField("stall.mcause_kept", mcause_q, 32'h8000_0003);

      // Reset asserted mid-FLUSH clears everything immediately.
      exc_valid = 1'b1; exc_cause = 4'd1; exc_tval = 32'h11;
      step();
      exc_valid = 1'b0;
      checkField("rstmid.in_flush", 32'(trap_flush), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      checkField("rstmid.trap_flush", 32'(trap_flush), 32'd0);
      checkField("rstmid.busy", 32'(busy), 32'd0);
      checkField("rstmid.pc_redirect", pc_redirect, RV);
      checkField("rstmid.mepc", mepc_q, 32'd0);
      checkField("rstmid.mcause", mcause_q, 32'd0);
      checkField("rstmid.mpie", 32'(mstatus_mpie), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      step();
      checkField("rstrel.busy", 32'(busy), 32'd0);
      checkField("rstrel.trap_flush", 32'(trap_flush), 32'd0);
      checkField("rstrel.pc_redirect", pc_redirect, RV);
      step();
      checkField("rstrel.still_idle", 32'(busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
